wb_sender: RTL and testbench

- Producer-side writeback output stage, instantiated once per execution pipe (ip0, ip1, lsp).
- Buffers completed results from the pipe's execute stage in a small in-order FIFO.
- Presents the FIFO head to the writeback arbiter using the dst/result/pc/wb_en/hipri/valid/ready handshake.
- Escalates long-stalled heads to high priority, and forwards queued values to issue for rs1/rs2 bypass.

---
 rtl/wb_sender.sv | 162 ++++++++++++++++
 tb/tb_wb_sender.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sender.sv
// Writeback output stage: in-order result FIFO presented to the writeback arbiter,
// with age-based priority promotion and rs1/rs2 bypass. Optional perf counters: WB_SENDER_STATS_EN.
module wb_sender #(
    parameter int DEPTH       = 2,
    parameter int STALL_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [4:0]  ex_dst,
    input  logic [63:0] ex_result,
    input  logic [63:0] ex_pc,
    input  logic        ex_wb_en,
    input  logic        ex_hipri,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_dst,
    output logic [63:0] wb_result,
    output logic [63:0] wb_pc,
    output logic        wb_wb_en,
    output logic        wb_hipri,
    input  logic [4:0]  fwd_rs1,
    output logic        fwd_rs1_hit,
    output logic [63:0] fwd_rs1_value,
    input  logic [4:0]  fwd_rs2,
    output logic        fwd_rs2_hit,
    output logic [63:0] fwd_rs2_value
`ifdef WB_SENDER_STATS_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_promote_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [3:0] AGE_LIM = 4'(STALL_LIMIT);

    typedef struct packed {
        logic [4:0]  dst;
        logic [63:0] result;
        logic [63:0] pc;
        logic        wb_en;
        logic        hipri;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [3:0]         age_q, age_d;
    entry_t             head_e;
    logic               push, pop, stalled;
    logic [PTR_W-1:0]   fwd_idx;

    assign head_e    = mem_q[head_q];
    assign wb_valid  = (count_q != '0);
    assign wb_dst    = head_e.dst;
    assign wb_result = head_e.result;
    assign wb_pc     = head_e.pc;
    assign wb_wb_en  = head_e.wb_en;
    assign wb_hipri  = wb_valid && head_e.wb_en && (head_e.hipri || (age_q >= AGE_LIM));
    assign pop       = wb_valid && wb_ready;
    assign stalled   = wb_valid && !wb_ready;
    // Full FIFO still accepts when the head leaves this same cycle.
    assign ex_ready  = (count_q < CNT_W'(DEPTH)) || pop;
    assign push      = ex_valid && ex_ready;

    always_comb begin
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        age_d   = age_q;
        if (push) begin
            mem_d[tail_q] = '{dst: ex_dst, result: ex_result, pc: ex_pc,
                              wb_en: ex_wb_en && (ex_dst != 5'd0), hipri: ex_hipri};
            tail_d = tail_q + PTR_W'(1);
        end
        if (pop) begin
            head_d = head_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        if (pop || !wb_valid) begin
            age_d = '0;
        end else if (age_q != 4'hf) begin
            age_d = age_q + 4'd1;
        end
    end

    // Walk oldest to youngest so the last match is the youngest entry.
    always_comb begin
        fwd_rs1_hit   = 1'b0;
        fwd_rs1_value = '0;
        fwd_rs2_hit   = 1'b0;
        fwd_rs2_value = '0;
        fwd_idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PTR_W'(i);
            if (CNT_W'(i) < count_q && mem_q[fwd_idx].wb_en) begin
                if (fwd_rs1 != 5'd0 && mem_q[fwd_idx].dst == fwd_rs1) begin
                    fwd_rs1_hit   = 1'b1;
                    fwd_rs1_value = mem_q[fwd_idx].result;
                end
                if (fwd_rs2 != 5'd0 && mem_q[fwd_idx].dst == fwd_rs2) begin
                    fwd_rs2_hit   = 1'b1;
                    fwd_rs2_value = mem_q[fwd_idx].result;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            age_q   <= '0;
        end else begin
            mem_q   <= mem_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            age_q   <= age_d;
        end
    end

`ifdef WB_SENDER_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, promote_cnt_q, promote_cnt_d;

    always_comb begin
        stall_cnt_d   = stall_cnt_q;
        promote_cnt_d = promote_cnt_q;
        if (stalled && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        // Age crosses the limit exactly once per head; self-hipri entries are not age promotions.
        if (stalled && head_e.wb_en && !head_e.hipri && age_q == AGE_LIM - 4'd1
            && promote_cnt_q != '1) begin
            promote_cnt_d = promote_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q   <= '0;
            promote_cnt_q <= '0;
        end else begin
            stall_cnt_q   <= stall_cnt_d;
            promote_cnt_q <= promote_cnt_d;
        end
    end

    assign perf_stall_cnt   = stall_cnt_q;
    assign perf_promote_cnt = promote_cnt_q;
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_wb_sender.sv
// Self-checking bench for wb_sender: hand-written vector table, corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_wb_sender;

    localparam int DEPTH       = 2;
    localparam int STALL_LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_ready, ex_wb_en, ex_hipri;
    logic [4:0]  ex_dst;
    logic [63:0] ex_result, ex_pc;
    logic        wb_valid, wb_ready, wb_wb_en, wb_hipri;
    logic [4:0]  wb_dst;
    logic [63:0] wb_result, wb_pc;
    logic [4:0]  fwd_rs1, fwd_rs2;
    logic        fwd_rs1_hit, fwd_rs2_hit;
    logic [63:0] fwd_rs1_value, fwd_rs2_value;

    wb_sender #(.DEPTH(DEPTH), .STALL_LIMIT(STALL_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_dst(ex_dst), .ex_result(ex_result),
        .ex_pc(ex_pc), .ex_wb_en(ex_wb_en), .ex_hipri(ex_hipri),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dst(wb_dst), .wb_result(wb_result),
        .wb_pc(wb_pc), .wb_wb_en(wb_wb_en), .wb_hipri(wb_hipri),
        .fwd_rs1(fwd_rs1), .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs1_value(fwd_rs1_value),
        .fwd_rs2(fwd_rs2), .fwd_rs2_hit(fwd_rs2_hit), .fwd_rs2_value(fwd_rs2_value)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: the queue in arrival order, plus stall age of its head.
    typedef struct {
        logic [4:0]  dst;
        logic [63:0] res;
        logic [63:0] pc;
        bit          wb_en;
        bit          hipri;
    } ent_t;
    ent_t mq[$];
    int   mage;

    task automatic model_fwd(input string name, input logic [4:0] rs, input logic hit,
                             input logic [63:0] val);
        bit          eh = 0;
        logic [63:0] ev = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (!eh && rs != 0 && mq[i].wb_en && mq[i].dst == rs) begin
                eh = 1;
                ev = mq[i].res;
            end
        end
        chk({name, "_hit"}, 64'(hit), 64'(eh));
        if (eh) chk({name, "_value"}, val, ev);
    endtask

    task automatic model_cmp_step();
        bit v   = mq.size() > 0;
        bit pop = v && wb_ready;
        bit rdy = (mq.size() < DEPTH) || pop;
        ent_t e;
        chk("m_ex_ready", 64'(ex_ready), 64'(rdy));
        chk("m_wb_valid", 64'(wb_valid), 64'(v));
        if (v) begin
            chk("m_wb_dst", 64'(wb_dst), 64'(mq[0].dst));
            chk("m_wb_result", wb_result, mq[0].res);
            chk("m_wb_pc", wb_pc, mq[0].pc);
            chk("m_wb_wb_en", 64'(wb_wb_en), 64'(mq[0].wb_en));
        end
        chk("m_wb_hipri", 64'(wb_hipri),
            64'(v && mq[0].wb_en && (mq[0].hipri || mage >= STALL_LIMIT)));
        model_fwd("m_fwd1", fwd_rs1, fwd_rs1_hit, fwd_rs1_value);
        model_fwd("m_fwd2", fwd_rs2, fwd_rs2_hit, fwd_rs2_value);
        if (rst) begin
            mq.delete();
            mage = 0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (pop || !v) mage = 0;
            else if (mage < 15) mage++;
            if (ex_valid && rdy) begin
                e.dst = ex_dst; e.res = ex_result; e.pc = ex_pc;
                e.wb_en = ex_wb_en && (ex_dst != 0); e.hipri = ex_hipri;
                mq.push_back(e);
            end
        end
    endtask

    // One clock: drive on the falling edge, check just after, state moves at the rising edge.
    task automatic cycle(input bit v, input logic [4:0] d, input logic [63:0] r, input bit we,
                         input bit hp, input bit rdy, input logic [4:0] r1, input logic [4:0] r2,
                         input bit rs);
        @(negedge clk);
        rst = rs; ex_valid = v; ex_dst = d; ex_result = r; ex_pc = ~r ^ 64'(d);
        ex_wb_en = we; ex_hipri = hp; wb_ready = rdy; fwd_rs1 = r1; fwd_rs2 = r2;
        #1;
        model_cmp_step();
    endtask

    task automatic idle(input bit rdy, input logic [4:0] r1);
        cycle(0, 5'd0, 64'd0, 0, 0, rdy, r1, 5'd0, 0);
    endtask

    typedef struct {
        bit          v;
        logic [4:0]  d;
        logic [63:0] r;
        bit          rdy;
        bit          e_ready;
        bit          e_valid;
        logic [4:0]  e_dst;
        logic [63:0] e_res;
    } vec_t;
    vec_t tbl[10];

    initial begin
        tbl[0] = '{1, 5'd5, 64'h1234, 1, 1, 0, 5'd0, 64'h0};
        tbl[1] = '{0, 5'd0, 64'h0,    1, 1, 1, 5'd5, 64'h1234};
        tbl[2] = '{0, 5'd0, 64'h0,    1, 1, 0, 5'd0, 64'h0};
        tbl[3] = '{1, 5'd1, 64'h11,   0, 1, 0, 5'd0, 64'h0};
        tbl[4] = '{1, 5'd2, 64'h22,   0, 1, 1, 5'd1, 64'h11};
        tbl[5] = '{1, 5'd3, 64'h33,   0, 0, 1, 5'd1, 64'h11};
        tbl[6] = '{1, 5'd3, 64'h33,   1, 1, 1, 5'd1, 64'h11};
        tbl[7] = '{0, 5'd0, 64'h0,    1, 1, 1, 5'd2, 64'h22};
        tbl[8] = '{0, 5'd0, 64'h0,    1, 1, 1, 5'd3, 64'h33};
        tbl[9] = '{0, 5'd0, 64'h0,    0, 1, 0, 5'd0, 64'h0};

        rst = 1; ex_valid = 0; ex_dst = 0; ex_result = 0; ex_pc = 0; ex_wb_en = 0;
        ex_hipri = 0; wb_ready = 0; fwd_rs1 = 0; fwd_rs2 = 0;
        mage = 0;
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        chk("reset_wb_valid", 64'(wb_valid), 64'd0);
        chk("reset_wb_hipri", 64'(wb_hipri), 64'd0);
        chk("reset_ex_ready", 64'(ex_ready), 64'd1);

        // Single pass, then fill/backpressure with simultaneous push+pop when full.
        foreach (tbl[k]) begin
            cycle(tbl[k].v, tbl[k].d, tbl[k].r, 1, 0, tbl[k].rdy, 5'd0, 5'd0, 0);
            chk($sformatf("tbl%0d_ex_ready", k), 64'(ex_ready), 64'(tbl[k].e_ready));
            chk($sformatf("tbl%0d_wb_valid", k), 64'(wb_valid), 64'(tbl[k].e_valid));
            if (tbl[k].e_valid) begin
                chk($sformatf("tbl%0d_wb_dst", k), 64'(wb_dst), 64'(tbl[k].e_dst));
                chk($sformatf("tbl%0d_wb_result", k), wb_result, tbl[k].e_res);
            end
        end

        // x0 write: retire without writeback, never promoted, never forwarded.
        cycle(1, 5'd0, 64'h99, 1, 1, 0, 5'd0, 5'd0, 0);
        for (int k = 0; k < 7; k++) begin
            idle(0, 5'd0);
            chk("x0_wb_en", 64'(wb_wb_en), 64'd0);
            chk("x0_hipri", 64'(wb_hipri), 64'd0);
            chk("x0_fwd_hit", 64'(fwd_rs1_hit), 64'd0);
        end
        idle(1, 5'd0);

        // Promotion from the 5th cycle of valid; next head restarts at age 0.
        cycle(1, 5'd9, 64'h900, 1, 0, 0, 5'd0, 5'd0, 0);
        chk("promo_empty", 64'(wb_valid), 64'd0);
        cycle(1, 5'd10, 64'hA00, 1, 0, 0, 5'd0, 5'd0, 0);
        chk("promo_c1_hipri", 64'(wb_hipri), 64'd0);
        for (int k = 2; k <= 5; k++) begin
            idle(0, 5'd0);
            chk($sformatf("promo_c%0d_hipri", k), 64'(wb_hipri), 64'(k >= 5));
            chk($sformatf("promo_c%0d_dst", k), 64'(wb_dst), 64'd9);
        end
        idle(1, 5'd0);
        chk("promo_pop_hipri", 64'(wb_hipri), 64'd1);
        idle(0, 5'd0);
        chk("promo_next_dst", 64'(wb_dst), 64'd10);
        chk("promo_next_hipri", 64'(wb_hipri), 64'd0);
        idle(1, 5'd0);

        // Forwarding picks the youngest; pushed-this-cycle misses, popped-this-cycle hits.
        cycle(1, 5'd7, 64'hA, 1, 0, 0, 5'd7, 5'd0, 0);
        chk("fwd_push_hit", 64'(fwd_rs1_hit), 64'd0);
        cycle(1, 5'd7, 64'hB, 1, 0, 0, 5'd7, 5'd0, 0);
        chk("fwd_one_val", fwd_rs1_value, 64'hA);
        idle(0, 5'd7);
        chk("fwd_two_hit", 64'(fwd_rs1_hit), 64'd1);
        chk("fwd_two_val", fwd_rs1_value, 64'hB);
        idle(1, 5'd7);
        chk("fwd_popA_val", fwd_rs1_value, 64'hB);
        idle(1, 5'd7);
        chk("fwd_popB_hit", 64'(fwd_rs1_hit), 64'd1);
        idle(0, 5'd7);
        chk("fwd_gone_hit", 64'(fwd_rs1_hit), 64'd0);

        // Reset mid-stall with a simultaneous push.
        cycle(1, 5'd3, 64'h3, 1, 0, 0, 5'd3, 5'd4, 0);
        cycle(1, 5'd4, 64'h4, 1, 0, 0, 5'd3, 5'd4, 0);
        cycle(1, 5'd5, 64'h5, 1, 0, 0, 5'd3, 5'd4, 1);
        cycle(0, 5'd0, 64'h0, 0, 0, 0, 5'd3, 5'd5, 0);
        chk("rst_wb_valid", 64'(wb_valid), 64'd0);
        chk("rst_ex_ready", 64'(ex_ready), 64'd1);
        chk("rst_fwd1_hit", 64'(fwd_rs1_hit), 64'd0);
        chk("rst_fwd2_hit", 64'(fwd_rs2_hit), 64'd0);
        idle(0, 5'd5);
        chk("rst_not_kept", 64'(wb_valid), 64'd0);

        // Random traffic: small register set to provoke forwarding hits and collisions.
        for (int k = 0; k < 600; k++) begin
            cycle(bit'($urandom_range(0, 2) != 0), 5'($urandom_range(0, 3)),
                  {32'($urandom), 32'($urandom)}, bit'($urandom_range(0, 3) != 0),
                  bit'($urandom_range(0, 7) == 0), bit'($urandom_range(0, 3) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  bit'($urandom_range(0, 63) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
